scanline_fetch_arbiter: RTL and testbench

SCANLINE_FETCH_ARBITER -- requirements
Module: scanline_fetch_arbiter

---
 rtl/scanline_fetch_arbiter.sv | 131 +++++++++++++
 tb/tb_scanline_fetch_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/scanline_fetch_arbiter.sv
// Scanline prefetch arbiter: streams one framebuffer line into a line buffer
// through a single memory port. A pixel writer gets the port only in cycles
// where the display side is not using it.
module scanline_fetch_arbiter #(
  parameter  int H_VISIBLE = 640,
  parameter  int V_VISIBLE = 480,
  parameter  int DATA_W    = 8,
  parameter  int ADDR_W    = $clog2(H_VISIBLE*V_VISIBLE),
  localparam int X_W       = $clog2(H_VISIBLE),
  localparam int Y_W       = $clog2(V_VISIBLE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              line_req,
  input  logic [Y_W-1:0]    line_y,
  output logic              lb_we,
  output logic [X_W-1:0]    lb_addr,
  output logic [DATA_W-1:0] lb_wdata,
  output logic              line_done,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              overrun,
  input  logic              overrun_clr
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  typedef struct packed {
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  state_t            state;
  logic [X_W-1:0]    x;
  logic [ADDR_W-1:0] base;
  logic              rd_vld;   // a read was issued last cycle
  logic [X_W-1:0]    rd_x;     // x of that read
  logic              accept;
  logic              busy_req;
  logic              last_x;
  mem_cmd_t          cmd;

  // Out-of-range lines are silently ignored; gating with rst_n keeps the
  // port quiet while reset is held even though these terms are combinational.
  assign accept   = rst_n && (state == IDLE) && line_req && (32'(line_y) < V_VISIBLE);
  assign busy_req = line_req && (state != IDLE);
  assign last_x   = (x == X_W'(H_VISIBLE - 1));

  // Writer may use the port in DRAIN (no read issued) or in an IDLE cycle
  // that does not start a line; display fetch always wins.
  assign wr_ready = rst_n && ((state == DRAIN) || ((state == IDLE) && !accept));

  // Line FSM: latch base on accept, walk x to the last pixel, one DRAIN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      x     <= '0;
      base  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            base  <= ADDR_W'(line_y) * ADDR_W'(H_VISIBLE);
            x     <= '0;
            state <= FETCH;
          end
        end
        FETCH: begin
          // x holds at the last pixel rather than wrapping
          if (last_x) state <= DRAIN;
          else        x     <= x + 1'b1;
        end
        DRAIN:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Read-return alignment: memory answers one cycle after the issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld <= 1'b0;
      rd_x   <= '0;
    end else begin
      rd_vld <= (state == FETCH);
      rd_x   <= x;
    end
  end

  assign lb_we     = rd_vld;
  assign lb_addr   = rd_vld ? rd_x : '0;
  assign lb_wdata  = rd_vld ? mem_rdata : '0;
  assign line_done = (state == DRAIN);

  // Port mux: fetch read, else granted writer, else all zero.
  always_comb begin
    cmd = '0;
    if (state == FETCH) begin
      cmd.en   = 1'b1;
      cmd.we   = 1'b0;
      cmd.addr = base + ADDR_W'(x);
    end else if (wr_valid && wr_ready) begin
      cmd.en    = 1'b1;
      cmd.we    = 1'b1;
      cmd.addr  = wr_addr;
      cmd.wdata = wr_data;
    end
  end

  assign mem_en    = cmd.en;
  assign mem_we    = cmd.we;
  assign mem_addr  = cmd.addr;
  assign mem_wdata = cmd.wdata;

  // Sticky overrun flag; a new event beats a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           overrun <= 1'b0;
    else if (busy_req)    overrun <= 1'b1;
    else if (overrun_clr) overrun <= 1'b0;
  end

endmodule

// File: tb/tb_scanline_fetch_arbiter.sv
// Bench for scanline_fetch_arbiter: directed scenarios with a line-buffer
// scoreboard fed from a behavioural framebuffer model.
module tb_scanline_fetch_arbiter;

  localparam int H = 640;
  localparam int V = 480;

  logic        clk;
  logic        rst_n;
  logic        line_req;
  logic [8:0]  line_y;
  logic        lb_we;
  logic [9:0]  lb_addr;
  logic [7:0]  lb_wdata;
  logic        line_done;
  logic        wr_valid;
  logic        wr_ready;
  logic [18:0] wr_addr;
  logic [7:0]  wr_data;
  logic        mem_en;
  logic        mem_we;
  logic [18:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        overrun;
  logic        overrun_clr;

  typedef struct { int x; logic [7:0] d; } lb_ent_t;
  lb_ent_t lbq[$];

  int checks = 0;
  int errors = 0;
  bit exp_ovr = 0;

  scanline_fetch_arbiter #(.H_VISIBLE(H), .V_VISIBLE(V), .DATA_W(8), .ADDR_W(19)) dut (
    .clk(clk), .rst_n(rst_n), .line_req(line_req), .line_y(line_y),
    .lb_we(lb_we), .lb_addr(lb_addr), .lb_wdata(lb_wdata), .line_done(line_done),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .overrun(overrun), .overrun_clr(overrun_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pix(input logic [18:0] a);
    return a[7:0] ^ a[15:8] ^ {5'b0, a[18:16]} ^ 8'hA5;
  endfunction

  // Framebuffer model: reads answer one cycle later, otherwise garbage.
  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= pix(mem_addr);
    else                   mem_rdata <= 8'($urandom);
  end

  // One full line. wr: writer holds a request throughout; inj_c: cycle with a
  // busy line_req (inj_clr adds a coincident clear); rst_c: cycle to assert
  // reset and abort; rel: release reset on the accept cycle.
  task automatic do_line(input int y, input bit wr, input int inj_c,
                         input bit inj_clr, input int rst_c, input bit rel);
    int      base;
    int      ea;
    lb_ent_t e;
    base = y * H;
    @(negedge clk);
    if (rel) rst_n = 1'b1;
    line_req = 1'b1;
    line_y   = 9'(y);
    #1;
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL accept_wr_ready y=%0d got %b exp 0", y, wr_ready); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL accept_mem_en y=%0d got %b exp 0", y, mem_en); end
    for (int c = 1; c <= H + 2; c++) begin
      @(negedge clk);
      line_req    = (c == inj_c);
      line_y      = 9'd3;
      overrun_clr = (c == inj_c) && inj_clr;
      if (c == H + 2) wr_valid = 1'b0;
      if (c == rst_c) begin
        rst_n = 1'b0;
        line_req = 1'b0;
        #1;
        checks++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin errors++; $display("FAIL abort_mem got en=%b we=%b a=%0d d=%0h exp 0", mem_en, mem_we, mem_addr, mem_wdata); end
        checks++; if ({lb_we, lb_addr, lb_wdata, line_done} !== '0) begin errors++; $display("FAIL abort_lb got we=%b a=%0d d=%0h done=%b exp 0", lb_we, lb_addr, lb_wdata, line_done); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL abort_overrun got %b exp 0", overrun); end
        exp_ovr = 0;
        lbq.delete();
        return;
      end
      #1;
      if (c <= H) begin
        ea = base + c - 1;
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 19'(ea)) begin errors++; $display("FAIL read y=%0d c=%0d got en=%b we=%b a=%0d exp en=1 we=0 a=%0d", y, c, mem_en, mem_we, mem_addr, ea); end
        e.x = c - 1; e.d = pix(19'(ea));
        lbq.push_back(e);
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL fetch_wr_ready c=%0d got %b exp 0", c, wr_ready); end
        checks++; if (line_done !== 1'b0) begin errors++; $display("FAIL early_done c=%0d got %b exp 0", c, line_done); end
      end else if (c == H + 1) begin
        checks++; if (line_done !== 1'b1) begin errors++; $display("FAIL drain_done y=%0d got %b exp 1", y, line_done); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL drain_wr_ready got %b exp 1", wr_ready); end
        checks++; if (mem_en !== wr || mem_we !== wr) begin errors++; $display("FAIL drain_mem got en=%b we=%b exp %b", mem_en, mem_we, wr); end
        if (wr) begin
          checks++; if (mem_addr !== wr_addr || mem_wdata !== wr_data) begin errors++; $display("FAIL drain_write got a=%0d d=%0h exp a=%0d d=%0h", mem_addr, mem_wdata, wr_addr, wr_data); end
        end
      end else begin
        checks++; if (mem_en !== 1'b0 || line_done !== 1'b0) begin errors++; $display("FAIL post_line got en=%b done=%b exp 0 0", mem_en, line_done); end
      end
      checks++; if (lb_we !== (c >= 2 && c <= H + 1)) begin errors++; $display("FAIL lb_we c=%0d got %b", c, lb_we); end
      if (lb_we === 1'b1) begin
        if (lbq.size() == 0) begin
          checks++; errors++; $display("FAIL lb_unexpected c=%0d got a=%0d exp none", c, lb_addr);
        end else begin
          e = lbq.pop_front();
          checks++; if (lb_addr !== 10'(e.x) || lb_wdata !== e.d) begin errors++; $display("FAIL lb_write c=%0d got a=%0d d=%0h exp a=%0d d=%0h", c, lb_addr, lb_wdata, e.x, e.d); end
        end
      end
      checks++; if (overrun !== exp_ovr) begin errors++; $display("FAIL overrun c=%0d got %b exp %b", c, overrun, exp_ovr); end
      if (line_req && c <= H + 1) exp_ovr = 1;
      else if (overrun_clr)       exp_ovr = 0;
    end
    checks++; if (lbq.size() != 0) begin errors++; $display("FAIL lb_missing got %0d pending exp 0", lbq.size()); end
    line_req = 1'b0; overrun_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; line_req = 1'b1; line_y = 9'd2;
    wr_valid = 1'b1; wr_addr = 19'd123; wr_data = 8'hFF; overrun_clr = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin errors++; $display("FAIL reset_mem got en=%b we=%b a=%0d d=%0h exp 0", mem_en, mem_we, mem_addr, mem_wdata); end
    checks++; if ({lb_we, lb_addr, lb_wdata, line_done} !== '0) begin errors++; $display("FAIL reset_lb got we=%b a=%0d d=%0h done=%b exp 0", lb_we, lb_addr, lb_wdata, line_done); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
    @(negedge clk);
    line_req = 1'b0; wr_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_writer_idle();
    @(negedge clk);
    wr_valid = 1'b1; wr_addr = 19'd1000; wr_data = 8'h3C;
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL idle_wr_ready got %b exp 1", wr_ready); end
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 19'd1000 || mem_wdata !== 8'h3C) begin errors++; $display("FAIL idle_write got en=%b we=%b a=%0d d=%0h exp 1 1 1000 3c", mem_en, mem_we, mem_addr, mem_wdata); end
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL idle_ready_novalid got %b exp 1", wr_ready); end
    checks++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin errors++; $display("FAIL idle_quiet got en=%b we=%b a=%0d d=%0h exp 0", mem_en, mem_we, mem_addr, mem_wdata); end
  endtask

  task automatic test_line2();
    do_line(2, 1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_writer_stall();
    @(negedge clk);
    wr_valid = 1'b1; wr_addr = 19'd77777; wr_data = 8'h96;
    do_line(5, 1'b1, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_overrun();
    do_line(1, 1'b0, 100, 1'b0, 0, 1'b0);
    @(negedge clk);
    overrun_clr = 1'b1;
    #1;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_before_clr got %b exp 1", overrun); end
    @(negedge clk);
    overrun_clr = 1'b0;
    #1;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_cleared got %b exp 0", overrun); end
    exp_ovr = 0;
    // busy request in DRAIN with a coincident clear: set wins
    do_line(6, 1'b0, H + 1, 1'b1, 0, 1'b0);
    @(negedge clk);
    #1;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set_wins got %b exp 1", overrun); end
    @(negedge clk);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    #1;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_cleared2 got %b exp 0", overrun); end
    exp_ovr = 0;
  endtask

  task automatic test_bad_line();
    int ys[2] = '{480, 511};
    foreach (ys[i]) begin
      @(negedge clk);
      line_req = 1'b1; line_y = 9'(ys[i]);
      #1;
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL bad_wr_ready y=%0d got %b exp 1", ys[i], wr_ready); end
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        line_req = 1'b0;
        #1;
        checks++; if (mem_en !== 1'b0 || lb_we !== 1'b0 || line_done !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL bad_line y=%0d c=%0d got en=%b lbwe=%b done=%b ovr=%b exp 0", ys[i], c, mem_en, lb_we, line_done, overrun); end
      end
    end
  endtask

  task automatic test_last_line();
    do_line(479, 1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_midline_reset();
    do_line(7, 1'b0, 0, 1'b0, 301, 1'b0);
    repeat (2) begin
      @(negedge clk);
      #1;
      checks++; if (line_done !== 1'b0 || lb_we !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("FAIL reset_hold got done=%b lbwe=%b en=%b exp 0", line_done, lb_we, mem_en); end
    end
    do_line(4, 1'b0, 0, 1'b0, 0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; line_req = 1'b0; line_y = '0; wr_valid = 1'b0;
    wr_addr = '0; wr_data = '0; overrun_clr = 1'b0;
    test_reset();
    test_writer_idle();
    test_line2();
    test_writer_stall();
    test_overrun();
    test_bad_line();
    test_last_line();
    test_midline_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
